// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) types, InvMixColumns coefficient matrix and field helpers.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] col_t;

    // Row i, column j coefficient of the InvMixColumns matrix.
    localparam byte_t INV_MC [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul_inv(input byte_t a, input byte_t coef);
        byte_t x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            8'h09:   return x8 ^ a;
            8'h0b:   return x8 ^ x2 ^ a;
            8'h0d:   return x8 ^ x4 ^ a;
            8'h0e:   return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/gf_inv_mul.sv
// Combinational GF(2^8) products of one byte by the four InvMixColumns coefficients.
module gf_inv_mul
    import aes_pkg::*;
(
    input  byte_t d_i,
    output byte_t x9_o,
    output byte_t xb_o,
    output byte_t xd_o,
    output byte_t xe_o
);

    byte_t x2, x4, x8;

    assign x2 = xtime(d_i);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    assign x9_o = x8 ^ d_i;
    assign xb_o = x8 ^ x2 ^ d_i;
    assign xd_o = x8 ^ x4 ^ d_i;
    assign xe_o = x8 ^ x4 ^ x2;

endmodule

// File: rtl/inv_mix_column_serial.sv
// Byte-serial AES InvMixColumns: four bytes in (row 0 first), one 32-bit column out
// on a held output register with valid/ready handshakes on both sides.
module inv_mix_column_serial
    import aes_pkg::*;
#(
    parameter bit ROW0_MSB = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d_out,
    output logic        busy
);

    logic [1:0] cnt_q, cnt_d;
    byte_t      acc_q [4];
    byte_t      acc_d [4];
    col_t       dout_q, dout_d;
    logic       ovld_q, ovld_d;

    byte_t      x9, xb, xd, xe;
    byte_t      prod [4];
    logic       fire_in;

    function automatic byte_t pick(input byte_t coef, input byte_t p9, input byte_t pb,
                                   input byte_t pd, input byte_t pe);
        case (coef)
            8'h09:   return p9;
            8'h0b:   return pb;
            8'h0d:   return pd;
            default: return pe;
        endcase
    endfunction

    gf_inv_mul u_gf_inv_mul (
        .d_i  (d_in),
        .x9_o (x9),
        .xb_o (xb),
        .xd_o (xd),
        .xe_o (xe)
    );

    // One multiplier shared by all rows; the byte position selects each row's coefficient.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod[i] = pick(INV_MC[i][cnt_q], x9, xb, xd, xe);
        end
    end

    // Only the 4th byte needs the output slot, so only it can stall.
    assign in_ready  = !((cnt_q == 2'd3) && ovld_q && !out_ready);
    assign fire_in   = in_valid && in_ready;
    assign busy      = (cnt_q != 2'd0);
    assign out_valid = ovld_q;
    assign d_out     = dout_q;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        dout_d = dout_q;
        ovld_d = ovld_q;

        if (out_ready) begin
            ovld_d = 1'b0;
        end

        if (clr) begin
            cnt_d = 2'd0;
            for (int i = 0; i < 4; i++) acc_d[i] = 8'h00;
        end else if (fire_in) begin
            if (cnt_q == 2'd3) begin
                for (int i = 0; i < 4; i++) begin
                    if (ROW0_MSB) dout_d[8*(3-i) +: 8] = acc_q[i] ^ prod[i];
                    else          dout_d[8*i +: 8]     = acc_q[i] ^ prod[i];
                    acc_d[i] = 8'h00;
                end
                ovld_d = 1'b1;
                cnt_d  = 2'd0;
            end else begin
                for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i] ^ prod[i];
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            acc_q  <= '{default: 8'h00};
            dout_q <= 32'h0;
            ovld_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
            ovld_q <= ovld_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_column_serial.sv
// Self-checking bench for inv_mix_column_serial: directed vectors plus a column-level model.
module tb_inv_mix_column_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic        or_man = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        out_ready;
    logic        in_ready, in_ready0;
    logic        out_valid, out_valid0;
    logic [31:0] d_out, d_out0;
    logic        busy, busy0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rt_q[$];
    logic [31:0] cur = 32'h0;
    int          nb = 0;
    int          stall_cnt = 0;
    int          ov_cycles = 0;
    int          handoffs = 0;

    assign out_ready = rnd_mode ? rnd_ready : or_man;

    always #5 clk = ~clk;

    inv_mix_column_serial #(.ROW0_MSB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out), .busy(busy)
    );

    inv_mix_column_serial #(.ROW0_MSB(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .d_in(d_in), .out_valid(out_valid0), .out_ready(out_ready), .d_out(d_out0), .busy(busy0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product; c = first row of the matrix, column packed row 0 in MSB.
    function automatic logic [31:0] circ(input logic [31:0] col, input logic [31:0] c);
        logic [7:0]  a [4];
        logic [7:0]  k [4];
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++) begin
            a[j] = col[31-8*j -: 8];
            k[j] = c[31-8*j -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = gmul(k[0], a[i]) ^ gmul(k[1], a[(i+1)%4]) ^
                             gmul(k[2], a[(i+2)%4]) ^ gmul(k[3], a[(i+3)%4]);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] col);
        return circ(col, 32'h0e0b0d09);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] col);
        return circ(col, 32'h02030101);
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Model and compare process: decisions for the coming rising edge, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            rt_q.delete();
            nb = 0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!(nb == 3 && exp_q.size() != 0 && !out_ready)));
            chk("in_ready_lsb", 32'(in_ready0), 32'(in_ready));
            chk("busy", 32'(busy), 32'(nb != 0));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("out_valid_lsb", 32'(out_valid0), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("d_out", d_out, exp_q[0]);
                chk("d_out_lsb", d_out0, bswap(exp_q[0]));
            end
            if (in_valid && !in_ready) stall_cnt++;
            if (out_valid) ov_cycles++;
            if (out_valid && out_ready) begin
                handoffs++;
                if (rt_q.size() != 0) chk("roundtrip", d_out, rt_q.pop_front());
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (clr) begin
                nb = 0;
            end else if (in_valid && in_ready) begin
                cur[31-8*nb -: 8] = d_in;
                nb++;
                if (nb == 4) begin
                    exp_q.push_back(inv_mix(cur));
                    nb = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Present a byte and hold it until accepted; leaves in_valid high.
    task automatic send(input logic [7:0] b);
        int  t;
        logic ok;
        in_valid = 1'b1;
        d_in     = b;
        t        = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
            if (ok) break;
            t++;
            if (t > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: byte %h not accepted after %0d cycles", b, t);
                break;
            end
        end
    endtask

    task automatic send_col(input logic [31:0] col);
        for (int j = 0; j < 4; j++) send(col[31-8*j -: 8]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [31:0] x;
        int          t;

        chk("pin_inv_a", inv_mix(32'h8e4da1bc), 32'hdb135345);
        chk("pin_inv_b", inv_mix(32'h9fdc589d), 32'hf20a225c);
        chk("pin_mix",   mix(32'hdb135345),     32'h8e4da1bc);

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_d_out", d_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1);

        // Test 1: single column, latency and busy.
        send(8'h8e);
        chk("t1_busy_first", 32'(busy), 32'h1);
        send(8'h4d);
        send(8'ha1);
        send(8'hbc);
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_d_out", d_out, 32'hdb135345);
        chk("t1_d_out_lsb", d_out0, 32'h455313db);
        chk("t1_busy_last", 32'(busy), 32'h0);
        idle(2);

        // Test 2: back-to-back columns.
        stall_cnt = 0;
        ov_cycles = 0;
        send_col(32'h9fdc589d);
        send_col(32'h4d7ebdf8);
        idle(3);
        chk("t2_no_stall", 32'(stall_cnt), 32'h0);
        chk("t2_ov_cycles", 32'(ov_cycles), 32'h2);

        // Test 3: held output, 4th byte of next column stalls.
        or_man    = 1'b0;
        stall_cnt = 0;
        send_col(32'hd5d5d7d6);
        idle(2);
        chk("t3_held_valid", 32'(out_valid), 32'h1);
        chk("t3_held", d_out, 32'hd4d4d4d5);
        send(8'h01);
        send(8'h01);
        send(8'h01);
        in_valid = 1'b1;
        d_in     = 8'h01;
        @(negedge clk);
        chk("t3_in_ready_low", 32'(in_ready), 32'h0);
        @(posedge clk);
        #2;
        idle(0);
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("t3_still_held", d_out, 32'hd4d4d4d5);
        chk("t3_stalled", 32'(stall_cnt != 0), 32'h1);
        or_man = 1'b1;
        @(posedge clk);
        #2;
        or_man   = 1'b0;
        in_valid = 1'b0;
        chk("t3_reload_valid", 32'(out_valid), 32'h1);
        chk("t3_reload", d_out, 32'h01010101);
        or_man = 1'b1;
        idle(2);

        // Test 4: clr aborts a partial column and drops its own byte.
        handoffs = 0;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        in_valid = 1'b1;
        d_in     = 8'h44;
        clr      = 1'b1;
        @(posedge clk);
        #2;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("t4_busy_clr", 32'(busy), 32'h0);
        chk("t4_no_out", 32'(out_valid), 32'h0);
        send_col(32'hc6c6c6c6);
        in_valid = 1'b0;
        chk("t4_d_out", d_out, 32'hc6c6c6c6);
        idle(3);
        chk("t4_handoffs", 32'(handoffs), 32'h1);

        // Test 5: asynchronous reset mid-column with a held result.
        or_man = 1'b0;
        send_col(32'h01010101);
        idle(1);
        send(8'h8e);
        send(8'h4d);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_d_out", d_out, 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        or_man = 1'b1;
        send_col(32'h8e4da1bc);
        in_valid = 1'b0;
        chk("t5_d_out", d_out, 32'hdb135345);
        idle(2);

        // Test 6: random round-trip columns with input gaps and output stalls.
        rnd_mode = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            x = $urandom;
            rt_q.push_back(x);
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send(mix(x) >> (8 * (3 - j)));
            end
        end
        in_valid = 1'b0;
        rnd_mode = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || nb != 0) && t < 100) begin
            idle(1);
            t++;
        end
        idle(1);
        chk("t6_drained", 32'(exp_q.size()), 32'h0);
        chk("t6_rt_drained", 32'(rt_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
